// File: rtl/mips_pkg.sv
// Shared MIPS32 pipeline definitions: reset vector, bubble word and fetch FSM states.
package mips_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    OUT   = 2'd2,
    ERR   = 2'd3
  } if_state_t;

  // A fetch address must be word aligned; anything else raises AdEL.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_fetch_unit_pc_reg.sv
// Program counter register: reset vector, absolute load, and +4 step (wraps mod 2^32).
module pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VAL = mips_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] load_val_i,
  input  logic        inc_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Load wins over increment so a redirect always lands exactly on its target.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + 32'd4;
    end
  end

  // PC state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_VAL;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/if_fetch_unit.sv
// MIPS32 instruction-fetch stage: single-outstanding imem requests, holds the
// fetched word across decode stalls, and services branch/jump/exception redirects.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
  parameter logic [31:0] NOP_INST = mips_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus_4,
  output logic [31:0] if_inst,
  output logic        if_addr_err
);

  import mips_pkg::*;

  if_state_t   state_q, state_d;
  logic        kill_q, kill_d;
  logic        pc_load, pc_inc;
  logic [31:0] pc;

  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_pc4_q, if_pc4_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        if_err_q, if_err_d;

  pc_reg #(
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst        (rst),
    .load_i     (pc_load),
    .load_val_i (redirect_pc),
    .inc_i      (pc_inc),
    .pc_o       (pc)
  );

  assign imem_req  = (state_q == FETCH);
  assign imem_addr = pc;

  // Next-state, kill tracking and output-register updates; redirect overrides all else.
  always_comb begin
    state_d    = state_q;
    kill_d     = kill_q;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_pc4_d   = if_pc4_q;
    if_inst_d  = if_inst_q;
    if_err_d   = if_err_q;

    if (redirect_en) begin
      if_valid_d = 1'b0;
      if (is_misaligned(redirect_pc)) begin
        // Present the AdEL bubble at once; any in-flight word must still be absorbed in ERR.
        if_valid_d = 1'b1;
        if_pc_d    = redirect_pc;
        if_pc4_d   = redirect_pc + 32'd4;
        if_inst_d  = NOP_INST;
        if_err_d   = 1'b1;
        state_d    = ERR;
        unique case (state_q)
          FETCH:   if (imem_ready) kill_d = 1'b1;
          WAIT:    kill_d = !imem_rvalid;
          ERR:     if (imem_rvalid) kill_d = 1'b0;
          default: ;
        endcase
      end else begin
        pc_load = 1'b1;
        unique case (state_q)
          FETCH: begin
            if (imem_ready) begin
              state_d = WAIT;
              kill_d  = 1'b1;
            end
          end
          WAIT: begin
            if (imem_rvalid) begin
              state_d = FETCH;
              kill_d  = 1'b0;
            end else begin
              kill_d  = 1'b1;
            end
          end
          OUT: state_d = FETCH;
          ERR: begin
            // A stale word still owed to us must drain before a new request goes out.
            if (kill_q && !imem_rvalid) begin
              state_d = WAIT;
            end else begin
              state_d = FETCH;
              kill_d  = 1'b0;
            end
          end
          default: state_d = FETCH;
        endcase
      end
    end else begin
      unique case (state_q)
        FETCH: if (imem_ready) state_d = WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = FETCH;
            end else begin
              if_valid_d = 1'b1;
              if_pc_d    = pc;
              if_pc4_d   = pc + 32'd4;
              if_inst_d  = imem_rdata;
              if_err_d   = 1'b0;
              pc_inc     = 1'b1;
              state_d    = OUT;
            end
          end
        end
        OUT: begin
          if (!id_stall) begin
            if_valid_d = 1'b0;
            state_d    = FETCH;
          end
        end
        ERR: begin
          if (!id_stall) if_valid_d = 1'b0;
          if (imem_rvalid) kill_d = 1'b0;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // FSM state and stale-response kill flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
    end
  end

  // IF/ID-facing output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid_q <= 1'b0;
      if_pc_q    <= RESET_PC;
      if_pc4_q   <= RESET_PC;
      if_inst_q  <= NOP_INST;
      if_err_q   <= 1'b0;
    end else begin
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_pc4_q   <= if_pc4_d;
      if_inst_q  <= if_inst_d;
      if_err_q   <= if_err_d;
    end
  end

  assign if_valid     = if_valid_q;
  assign if_pc        = if_pc_q;
  assign if_pc_plus_4 = if_pc4_q;
  assign if_inst      = if_inst_q;
  assign if_addr_err  = if_err_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus a randomized run against a
// transaction-level model (expected PC stream, memory returning addr ^ A5A5A5A5).
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus_4;
  logic [31:0] if_inst;
  logic        if_addr_err;

  if_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .id_stall     (id_stall),
    .redirect_en  (redirect_en),
    .redirect_pc  (redirect_pc),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_pc_plus_4 (if_pc_plus_4),
    .if_inst      (if_inst),
    .if_addr_err  (if_addr_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // memory model state
  bit          mem_pend;
  logic [31:0] mem_addr;
  int          mem_cnt;
  bit          rand_mem;
  int          fixed_lat;
  logic [31:0] req_log[$];

  // per-cycle observations taken just before the edge
  bit          s_hs, s_xfer, s_ovl, s_redir;
  logic [31:0] s_addr, s_pc, s_pc4, s_inst, s_rpc;
  bit          s_err;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hA5A5_A5A5;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    id_stall = 1'b0; redirect_en = 1'b0; redirect_pc = 32'h0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    mem_pend = 1'b0; mem_cnt = 0; req_log.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One clock: drive memory, sample pre-edge observations, advance, update memory model.
  task automatic step();
    bit rv;
    if (mem_pend && mem_cnt == 0) begin
      imem_rvalid = 1'b1; imem_rdata = memf(mem_addr);
    end else begin
      imem_rvalid = 1'b0; imem_rdata = $urandom;
    end
    imem_ready = rand_mem ? ($urandom_range(0, 1) == 1) : 1'b1;
    #1;
    rv      = imem_rvalid;
    s_hs    = imem_req && imem_ready;
    s_addr  = imem_addr;
    s_redir = redirect_en;
    s_rpc   = redirect_pc;
    s_xfer  = if_valid && !id_stall && !redirect_en;
    s_pc = if_pc; s_pc4 = if_pc_plus_4; s_inst = if_inst; s_err = if_addr_err;
    s_ovl   = 1'b0;
    @(posedge clk); #1;
    if (rv) mem_pend = 1'b0;
    else if (mem_pend && mem_cnt > 0) mem_cnt--;
    if (s_hs) begin
      s_ovl    = mem_pend;
      mem_pend = 1'b1;
      mem_addr = s_addr;
      mem_cnt  = rand_mem ? int'($urandom_range(0, 3)) : fixed_lat;
      req_log.push_back(s_addr);
    end
  endtask

  task automatic test_reset();
    rand_mem = 1'b0; fixed_lat = 0;
    do_reset();
    n_checks++; if (if_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", if_valid); else n_pass++;
    n_checks++; if (if_pc !== 32'h0000_3000) $display("FAIL reset_pc: got %h want 00003000", if_pc); else n_pass++;
    n_checks++; if (if_pc_plus_4 !== 32'h0000_3000) $display("FAIL reset_pc4: got %h want 00003000", if_pc_plus_4); else n_pass++;
    n_checks++; if (if_inst !== 32'h0) $display("FAIL reset_inst: got %h want 00000000", if_inst); else n_pass++;
    n_checks++; if (if_addr_err !== 1'b0) $display("FAIL reset_err: got %b want 0", if_addr_err); else n_pass++;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3000)
      $display("FAIL reset_req: got req=%b addr=%h want req=1 addr=00003000", imem_req, imem_addr); else n_pass++;
  endtask

  task automatic test_stream();
    int vcyc[$];
    logic [31:0] fpc, fpc4, finst;
    fpc = 0; fpc4 = 0; finst = 0;
    rand_mem = 1'b0; fixed_lat = 0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step();
      if (if_valid === 1'b1) begin
        if (vcyc.size() == 0) begin fpc = if_pc; fpc4 = if_pc_plus_4; finst = if_inst; end
        vcyc.push_back(i);
      end
    end
    n_checks++; if (req_log.size() < 3) $display("FAIL stream_reqs: got %0d requests want 3", req_log.size()); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      logic [31:0] want;
      want = 32'h0000_3000 + 32'(4 * k);
      n_checks++;
      if (k >= req_log.size()) $display("FAIL stream_addr%0d: got none want %h", k, want);
      else if (req_log[k] !== want) $display("FAIL stream_addr%0d: got %h want %h", k, req_log[k], want);
      else n_pass++;
    end
    n_checks++;
    if (vcyc.size() != 3 || vcyc[1] - vcyc[0] != 3 || vcyc[2] - vcyc[1] != 3)
      $display("FAIL stream_cadence: got %0d valid cycles want 3 spaced by 3", vcyc.size());
    else n_pass++;
    n_checks++; if (fpc !== 32'h0000_3000) $display("FAIL stream_pc: got %h want 00003000", fpc); else n_pass++;
    n_checks++; if (fpc4 !== 32'h0000_3004) $display("FAIL stream_pc4: got %h want 00003004", fpc4); else n_pass++;
    n_checks++; if (finst !== 32'hA5A5_95A5) $display("FAIL stream_inst: got %h want a5a595a5", finst); else n_pass++;
  endtask

  task automatic test_stall();
    bit found;
    logic [31:0] hpc, hpc4, hinst;
    found = 1'b0;
    rand_mem = 1'b0; fixed_lat = 0;
    do_reset();
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (if_valid === 1'b1 && if_pc === 32'h0000_3004) found = 1'b1;
    end
    n_checks++; if (!found) $display("FAIL stall_reach: got no output at 00003004 want one"); else n_pass++;
    hpc = if_pc; hpc4 = if_pc_plus_4; hinst = if_inst;
    id_stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if (if_valid !== 1'b1 || if_pc !== hpc || if_pc_plus_4 !== hpc4 || if_inst !== hinst || imem_req !== 1'b0)
        $display("FAIL stall_hold%0d: got v=%b pc=%h inst=%h req=%b want v=1 pc=%h inst=%h req=0",
                 k, if_valid, if_pc, if_inst, imem_req, hpc, hinst);
      else n_pass++;
    end
    id_stall = 1'b0;
    step();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3008)
      $display("FAIL stall_release: got req=%b addr=%h want req=1 addr=00003008", imem_req, imem_addr); else n_pass++;
    n_checks++; if (if_valid !== 1'b0) $display("FAIL stall_drop: got %b want 0", if_valid); else n_pass++;
  endtask

  task automatic test_redirect_wait();
    bit found;
    found = 1'b0;
    rand_mem = 1'b0; fixed_lat = 2;
    do_reset();
    for (int i = 0; i < 30 && req_log.size() < 2; i++) step();
    redirect_en = 1'b1; redirect_pc = 32'h0000_4000;
    step();
    redirect_en = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (if_valid === 1'b1) found = 1'b1;
    end
    n_checks++; if (!found || if_pc !== 32'h0000_4000)
      $display("FAIL rdw_pc: got found=%b pc=%h want pc=00004000", found, if_pc); else n_pass++;
    n_checks++; if (if_inst !== memf(32'h0000_4000))
      $display("FAIL rdw_inst: got %h want %h", if_inst, memf(32'h0000_4000)); else n_pass++;
    n_checks++; if (req_log.size() != 3 || req_log[2] !== 32'h0000_4000)
      $display("FAIL rdw_req: got %0d requests want 3 ending at 00004000", req_log.size()); else n_pass++;
  endtask

  task automatic test_redirect_rvalid();
    bit found;
    found = 1'b0;
    rand_mem = 1'b0; fixed_lat = 0;
    do_reset();
    for (int i = 0; i < 30 && req_log.size() < 2; i++) step();
    redirect_en = 1'b1; redirect_pc = 32'h0000_5000;
    step();
    redirect_en = 1'b0;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_5000)
      $display("FAIL rdr_fetch: got req=%b addr=%h want req=1 addr=00005000", imem_req, imem_addr); else n_pass++;
    n_checks++; if (if_valid !== 1'b0) $display("FAIL rdr_valid: got %b want 0", if_valid); else n_pass++;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (if_valid === 1'b1) found = 1'b1;
    end
    n_checks++; if (!found || if_pc !== 32'h0000_5000 || if_inst !== memf(32'h0000_5000))
      $display("FAIL rdr_next: got found=%b pc=%h inst=%h want pc=00005000 inst=%h",
               found, if_pc, if_inst, memf(32'h0000_5000)); else n_pass++;
  endtask

  task automatic test_misaligned();
    bit found;
    found = 1'b0;
    rand_mem = 1'b0; fixed_lat = 2;
    do_reset();
    step();
    redirect_en = 1'b1; redirect_pc = 32'h0000_6002;
    step();
    redirect_en = 1'b0;
    n_checks++; if (if_valid !== 1'b1 || if_addr_err !== 1'b1)
      $display("FAIL mis_flag: got v=%b err=%b want v=1 err=1", if_valid, if_addr_err); else n_pass++;
    n_checks++; if (if_pc !== 32'h0000_6002 || if_pc_plus_4 !== 32'h0000_6006)
      $display("FAIL mis_pc: got pc=%h pc4=%h want 00006002 00006006", if_pc, if_pc_plus_4); else n_pass++;
    n_checks++; if (if_inst !== 32'h0) $display("FAIL mis_inst: got %h want 00000000", if_inst); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      n_checks++; if (imem_req !== 1'b0) $display("FAIL mis_noreq%0d: got req=%b want 0", k, imem_req); else n_pass++;
      step();
    end
    n_checks++; if (if_valid !== 1'b0) $display("FAIL mis_drop: got %b want 0", if_valid); else n_pass++;
    redirect_en = 1'b1; redirect_pc = 32'h0000_8000;
    step();
    redirect_en = 1'b0;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_8000)
      $display("FAIL mis_refetch: got req=%b addr=%h want req=1 addr=00008000", imem_req, imem_addr); else n_pass++;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (if_valid === 1'b1) found = 1'b1;
    end
    n_checks++; if (!found || if_pc !== 32'h0000_8000 || if_inst !== memf(32'h0000_8000) || if_addr_err !== 1'b0)
      $display("FAIL mis_next: got found=%b pc=%h inst=%h err=%b want pc=00008000 inst=%h err=0",
               found, if_pc, if_inst, if_addr_err, memf(32'h0000_8000)); else n_pass++;
  endtask

  task automatic test_wrap();
    bit found;
    int n;
    found = 1'b0;
    rand_mem = 1'b0; fixed_lat = 0;
    do_reset();
    redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_en = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (if_valid === 1'b1) found = 1'b1;
    end
    n_checks++; if (!found || if_pc !== 32'hFFFF_FFFC || if_inst !== memf(32'hFFFF_FFFC))
      $display("FAIL wrap_pc: got found=%b pc=%h inst=%h want pc=fffffffc", found, if_pc, if_inst); else n_pass++;
    n_checks++; if (if_pc_plus_4 !== 32'h0)
      $display("FAIL wrap_pc4: got %h want 00000000", if_pc_plus_4); else n_pass++;
    n = req_log.size();
    for (int i = 0; i < 20 && req_log.size() == n; i++) step();
    n_checks++; if (req_log.size() == n || req_log[req_log.size()-1] !== 32'h0)
      $display("FAIL wrap_addr: got %0d new requests want next addr 00000000", req_log.size() - n); else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    rand_mem = 1'b0; fixed_lat = 3;
    do_reset();
    for (int i = 0; i < 30 && req_log.size() < 2; i++) step();
    n_checks++; if (if_pc_plus_4 !== 32'h0000_3004)
      $display("FAIL rmw_pre: got pc4=%h want 00003004", if_pc_plus_4); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (if_valid !== 1'b0 || if_pc !== 32'h0000_3000 || if_pc_plus_4 !== 32'h0000_3000 ||
                    if_inst !== 32'h0 || if_addr_err !== 1'b0)
      $display("FAIL rmw_outs: got v=%b pc=%h pc4=%h inst=%h err=%b want reset values",
               if_valid, if_pc, if_pc_plus_4, if_inst, if_addr_err); else n_pass++;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3000)
      $display("FAIL rmw_req: got req=%b addr=%h want req=1 addr=00003000", imem_req, imem_addr); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_pend = 1'b0; req_log.delete();
    step();
    n_checks++; if (req_log.size() != 1 || req_log[0] !== 32'h0000_3000)
      $display("FAIL rmw_restart: got %0d requests want one at 00003000", req_log.size()); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    int xfers;
    exp_pc = 32'h0000_3000; xfers = 0;
    rand_mem = 1'b1;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      id_stall    = ($urandom_range(0, 3) == 0);
      redirect_en = ($urandom_range(0, 19) == 0);
      redirect_pc = {16'h0001, 14'($urandom), 2'b00};
      step();
      if (s_redir) begin
        exp_pc = s_rpc;
        n_checks++; if (if_valid !== 1'b0) $display("FAIL rnd_redir_drop%0d: got v=%b want 0", i, if_valid); else n_pass++;
      end
      if (s_xfer) begin
        n_checks++;
        if (s_pc !== exp_pc || s_inst !== memf(exp_pc) || s_pc4 !== exp_pc + 32'd4 || s_err !== 1'b0)
          $display("FAIL rnd_xfer%0d: got pc=%h inst=%h pc4=%h err=%b want pc=%h inst=%h",
                   i, s_pc, s_inst, s_pc4, s_err, exp_pc, memf(exp_pc));
        else n_pass++;
        exp_pc = exp_pc + 32'd4;
        xfers++;
      end
      if (s_hs && !s_redir) begin
        n_checks++; if (s_addr !== exp_pc) $display("FAIL rnd_addr%0d: got %h want %h", i, s_addr, exp_pc); else n_pass++;
      end
      if (s_hs) begin
        n_checks++; if (s_ovl) $display("FAIL rnd_outstanding%0d: got 2 in flight want 1", i); else n_pass++;
      end
    end
    redirect_en = 1'b0; id_stall = 1'b0;
    n_checks++; if (xfers < 20) $display("FAIL rnd_progress: got %0d transfers want >= 20", xfers); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_rvalid();
    test_misaligned();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
